obs_seq_framer: RTL and testbench
=================================

# obs_seq_framer

Sequential front-end for the combinational HMM forward-probability evaluator. It accepts observation symbols one per handshake and assembles them into an `OBSERVED_LEN`-entry frame that drives `observed_seq` directly. It waits a fixed settle time for the alpha chain to resolve, then registers `probability` and returns it to the consumer over a valid/ready handshake.

## Interface

- `OBSERVED_STATES`, default from defs.sv, symbol alphabet size; symbol width `SW = $clog2(OBSERVED_STATES)`.
- `OBSERVED_LEN`, default from defs.sv, symbols per frame; index width `$clog2(OBSERVED_LEN)`.
- `DATA_PREC`, default from defs.sv, probability width.
- `SETTLE_CYCLES`, default 4, cycles allowed for HMM combinational settling; legal range 1 to 255.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `abort`  in  1  synchronous frame abort.
- `sym_in`  in  SW  incoming symbol.
- `sym_valid`  in  1  `sym_in` is valid.
- `sym_ready`  out  1  framer can accept a symbol.
- `seq_out`  out  SW x OBSERVED_LEN, unpacked `[OBSERVED_LEN-1:0]`  frame to HMM `observed_seq`.
- `hmm_prob`  in  DATA_PREC  HMM `probability` output.
- `prob_out`  out  DATA_PREC  captured frame probability.
- `prob_valid`  out  1  `prob_out` is valid.
- `prob_ready`  in  1  consumer accepts `prob_out`.
- `sym_err`  out  1  sticky flag: an out-of-range symbol was seen in the current frame.
- `frame_count`  out  16  count of completed result handshakes; wraps modulo 2^16.

## Operation

- FSM states: FILL, SETTLE, HOLD. Reset state is FILL.
- **FILL**
  - `sym_ready` = 1.
  - On `sym_valid && sym_ready`, write `sym_in` to `seq_out[wr_idx]` and increment `wr_idx`. The first accepted symbol lands in index 0.
  - When the accepted symbol has `wr_idx == OBSERVED_LEN-1`, go to SETTLE, load `settle_cnt = SETTLE_CYCLES`, and clear `wr_idx` to 0.
- **SETTLE**
  - `sym_ready` = 0. `seq_out` is frozen.
  - `settle_cnt` decrements every cycle.
  - On the edge where `settle_cnt == 1`: `prob_out <= hmm_prob`, `prob_valid <= 1`, go to HOLD.
- **HOLD**
  - `sym_ready` = 0. `seq_out` and `prob_out` are frozen.
  - On `prob_valid && prob_ready`: `prob_valid <= 0`, `frame_count` increments, `sym_err <= 0`, go to FILL.
- **Out-of-range symbol** (`sym_in >= OBSERVED_STATES`, accepted in FILL):
  - The symbol is stored as 0 and `sym_err <= 1`.
  - The frame still completes normally.
- **`abort`**:
  - Highest priority, effective in any state.
  - Next state FILL, `wr_idx = 0`, `prob_valid = 0`, `sym_err = 0`, `settle_cnt = 0`.
  - Any symbol handshake in the same cycle is discarded.
  - `seq_out` contents and `frame_count` are unchanged.
- **Reset values**:
  - `seq_out` all 0, `prob_out` 0, `prob_valid` 0, `sym_err` 0, `frame_count` 0.
  - Internal state: `wr_idx` 0, `settle_cnt` 0, state FILL.
  - `sym_ready` is decoded from state, so it is 1 once in FILL, including during reset.
- **Width rules**:
  - `prob_out` is a straight register of `hmm_prob`; no arithmetic.
  - `settle_cnt` is 8 bits.
  - `frame_count` wraps 0xFFFF to 0x0000 without a flag.

## Timing

- Symbol throughput: one per cycle while in FILL.
- Latency: if the last symbol is accepted at edge k, `prob_valid` is high after edge k+SETTLE_CYCLES. The HMM therefore sees a stable frame for exactly SETTLE_CYCLES full cycles before capture.
- The consumer may hold `prob_ready` high permanently. HOLD then lasts 1 cycle, and the next FILL begins at edge k+SETTLE_CYCLES+1.
- Minimum frame period: OBSERVED_LEN + SETTLE_CYCLES + 1 cycles.
- `prob_out` and `prob_valid` stay stable while `prob_valid && !prob_ready`.
- `rst_n` asserted mid-frame clears everything immediately and asynchronously. Partial frames are lost.

## Test plan

Use OBSERVED_LEN=4, OBSERVED_STATES=3, SETTLE_CYCLES=4, with a stub HMM that drives `hmm_prob` from `seq_out`.

1. **Basic frame:** feed symbols 2,0,1,1 back-to-back with `prob_ready=1`. Expect `seq_out[0..3]` = 2,0,1,1. Expect `prob_valid` high exactly 4 cycles after the 4th accept, `prob_out` equal to the stub value, and `frame_count`=1.
2. **Backpressure:** hold `prob_ready=0` for 10 cycles after `prob_valid` rises. Expect `prob_out` stable, `sym_ready=0` throughout, and symbols offered during this window not accepted. On release, expect exactly one handshake.
3. **Gapped input:** toggle `sym_valid` 1,0,1,0,... Expect only the 4 valid symbols stored, in order, and SETTLE entered only after the 4th.
4. **Out-of-range symbol:** send symbol 3 as the 2nd symbol. Expect `seq_out[1]`=0 and `sym_err`=1 until the result handshake, then 0.
5. **Abort:** pulse `abort` after 2 symbols. Expect the next 4 symbols to fill indices 0..3. Then pulse `abort` in HOLD: expect `prob_valid` to drop without a handshake and `frame_count` to stay unchanged.
6. **Reset and wrap:** assert `rst_n=0` during SETTLE and expect all outputs at their reset values with no pending `prob_valid`. Force `frame_count` to 0xFFFF, complete one frame, and expect 0x0000.

Source files
------------

// File: rtl/obs_seq_framer.sv
// Sequential front-end for the combinational HMM evaluator: collects one frame of
// observation symbols, waits for the alpha chain to settle, then hands back the probability.
module obs_seq_framer #(
    parameter int OBSERVED_STATES = 3,
    parameter int OBSERVED_LEN    = 4,
    parameter int DATA_PREC       = 16,
    parameter int SETTLE_CYCLES   = 4,
    localparam int SW = (OBSERVED_STATES > 2) ? $clog2(OBSERVED_STATES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic [SW-1:0]        sym_in,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    output logic [SW-1:0]        seq_out [OBSERVED_LEN-1:0],
    input  logic [DATA_PREC-1:0] hmm_prob,
    output logic [DATA_PREC-1:0] prob_out,
    output logic                 prob_valid,
    input  logic                 prob_ready,
    output logic                 sym_err,
    output logic [15:0]          frame_count,
    output logic [1:0]           dbg_state
);

    localparam int IW = (OBSERVED_LEN > 1) ? $clog2(OBSERVED_LEN) : 1;
    localparam logic [SW:0]   MAX_SYM  = (SW + 1)'(OBSERVED_STATES);
    localparam logic [IW-1:0] LAST_IDX = IW'(OBSERVED_LEN - 1);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_wr_idx;
    logic [7:0]            r_settle_cnt;
    logic [SW-1:0]         r_seq [OBSERVED_LEN-1:0];
    logic [DATA_PREC-1:0]  r_prob;
    logic                  r_prob_valid;
    logic                  r_sym_err;
    logic [15:0]           r_frame_count;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_result_taken;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds data stable while valid && !ready; ready never depends on valid.
    assign sym_ready      = (r_state == S_FILL);
    assign w_accept       = sym_valid && sym_ready;
    assign w_in_range     = ({1'b0, sym_in} < MAX_SYM);
    assign w_result_taken = r_prob_valid && prob_ready;

    assign seq_out     = r_seq;
    assign prob_out    = r_prob;
    assign prob_valid  = r_prob_valid;
    assign sym_err     = r_sym_err;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FILL;
            r_wr_idx      <= '0;
            r_settle_cnt  <= '0;
            r_prob        <= '0;
            r_prob_valid  <= 1'b0;
            r_sym_err     <= 1'b0;
            r_frame_count <= '0;
            for (int i = 0; i < OBSERVED_LEN; i++) begin
                r_seq[i] <= '0;
            end
        end else if (abort) begin
            // Frame contents and the completed-frame count survive an abort.
            r_state      <= S_FILL;
            r_wr_idx     <= '0;
            r_settle_cnt <= '0;
            r_prob_valid <= 1'b0;
            r_sym_err    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_seq[r_wr_idx] <= w_in_range ? sym_in : '0;
                        if (!w_in_range) begin
                            r_sym_err <= 1'b1;
                        end
                        if (r_wr_idx == LAST_IDX) begin
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= SETTLE_LOAD;
                            r_wr_idx     <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + IW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    // The frame has been stable for SETTLE_CYCLES full cycles at this capture.
                    if (r_settle_cnt <= 8'd1) begin
                        r_settle_cnt <= '0;
                        r_prob       <= hmm_prob;
                        r_prob_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_result_taken) begin
                        r_prob_valid  <= 1'b0;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_sym_err     <= 1'b0;
                        r_state       <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obs_seq_framer.sv
// Self-checking bench for obs_seq_framer: directed scenarios plus randomized frames
// checked against a frame-level reference model and an expected-result queue.
module tb_obs_seq_framer;

    localparam int LEN    = 4;
    localparam int NST    = 3;
    localparam int DP     = 16;
    localparam int SETTLE = 4;
    localparam int SW     = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          abort = 1'b0;
    logic [SW-1:0] sym_in = '0;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic [SW-1:0] seq_out [LEN-1:0];
    logic [DP-1:0] hmm_prob;
    logic [DP-1:0] prob_out;
    logic          prob_valid;
    logic          prob_ready = 1'b0;
    logic          sym_err;
    logic [15:0]   frame_count;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the frame should hold, how far it has filled.
    logic [SW-1:0] exp_seq [LEN];
    int            exp_fill = 0;
    logic          exp_err = 1'b0;
    logic [15:0]   exp_fc = '0;
    logic [DP-1:0] exp_q [$];

    obs_seq_framer #(
        .OBSERVED_STATES(NST),
        .OBSERVED_LEN   (LEN),
        .DATA_PREC      (DP),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .seq_out    (seq_out),
        .hmm_prob   (hmm_prob),
        .prob_out   (prob_out),
        .prob_valid (prob_valid),
        .prob_ready (prob_ready),
        .sym_err    (sym_err),
        .frame_count(frame_count),
        .dbg_state  (dbg_state)
    );

    // Stub HMM: probability is a fixed tag with the frame packed in, index 0 most significant.
    assign hmm_prob = 16'h5000 | {8'h00, seq_out[0], seq_out[1], seq_out[2], seq_out[3]};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DP-1:0] model_prob();
        int v;
        v = 0;
        for (int i = 0; i < LEN; i++) begin
            v = v * 4 + int'(exp_seq[i]);
        end
        return DP'(32'h5000 + v);
    endfunction

    function automatic logic [4*SW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {SW'(d), SW'(c), SW'(b), SW'(a)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LEN; i++) exp_seq[i] = '0;
        exp_fill = 0;
        exp_err  = 1'b0;
        exp_fc   = '0;
        exp_q.delete();
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < LEN; i++) begin
            chk(tag, 32'(seq_out[i]), 32'(exp_seq[i]));
        end
    endtask

    // Offer one symbol after `gap` idle cycles; it must be taken on the first edge.
    task automatic push_sym(input logic [SW-1:0] s, input int gap);
        sym_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
            chk("gap_ready", sym_ready, 1);
            chk("gap_fill_kept", 32'(seq_out[exp_fill]), 32'(exp_seq[exp_fill]));
        end
        sym_valid = 1'b1;
        sym_in    = s;
        chk("fill_ready", sym_ready, 1);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        exp_seq[exp_fill] = (int'(s) >= NST) ? '0 : s;
        if (int'(s) >= NST) exp_err = 1'b1;
        chk("seq_write", 32'(seq_out[exp_fill]), 32'(exp_seq[exp_fill]));
        chk("err_fill", sym_err, exp_err);
        exp_fill++;
        if (exp_fill == LEN) begin
            exp_q.push_back(model_prob());
            exp_fill = 0;
        end
    endtask

    // Called right after the last accept: prob_valid must rise exactly SETTLE edges later.
    task automatic wait_result();
        for (int i = 1; i <= SETTLE; i++) begin
            @(posedge clk); #1;
            if (i < SETTLE) begin
                chk("settle_pv", prob_valid, 0);
                chk("settle_ready", sym_ready, 0);
            end
        end
        chk("latency_pv", prob_valid, 1);
        chk("hold_ready", sym_ready, 0);
    endtask

    task automatic consume(input int stall);
        logic [DP-1:0] exp_p;
        exp_p = exp_q.pop_front();
        chk("prob_out", prob_out, exp_p);
        check_frame("seq_frame");
        chk("err_hold", sym_err, exp_err);
        if (stall > 0) prob_ready = 1'b0;
        repeat (stall) begin
            sym_valid = 1'b1;
            sym_in    = SW'($urandom_range(0, 2));
            @(posedge clk); #1;
            chk("bp_pv", prob_valid, 1);
            chk("bp_prob", prob_out, exp_p);
            chk("bp_ready", sym_ready, 0);
            chk("bp_fc", frame_count, exp_fc);
        end
        sym_valid = 1'b0;
        check_frame("bp_seq_kept");
        prob_ready = 1'b1;
        @(posedge clk); #1;
        prob_ready = 1'b0;
        exp_fc  = exp_fc + 16'd1;
        exp_err = 1'b0;
        chk("hs_pv", prob_valid, 0);
        chk("hs_fc", frame_count, exp_fc);
        chk("hs_err", sym_err, 0);
        chk("hs_ready", sym_ready, 1);
        @(posedge clk); #1;
        chk("hs_single", frame_count, exp_fc);
    endtask

    task automatic run_frame(input logic [4*SW-1:0] f, input int gap, input int stall);
        for (int i = 0; i < LEN; i++) begin
            push_sym(f[i*SW +: SW], gap);
        end
        wait_result();
        consume(stall);
    endtask

    task automatic pulse_abort(input logic [SW-1:0] junk);
        abort     = 1'b1;
        sym_valid = 1'b1;
        sym_in    = junk;
        @(posedge clk); #1;
        abort     = 1'b0;
        sym_valid = 1'b0;
        exp_fill  = 0;
        exp_err   = 1'b0;
        chk("abort_ready", sym_ready, 1);
        chk("abort_pv", prob_valid, 0);
        chk("abort_err", sym_err, 0);
        chk("abort_fc", frame_count, exp_fc);
        check_frame("abort_seq_kept");
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, sym_ready, 1);
        chk({tag, "_pv"}, prob_valid, 0);
        chk({tag, "_prob"}, prob_out, 0);
        chk({tag, "_err"}, sym_err, 0);
        chk({tag, "_fc"}, frame_count, 0);
        check_frame({tag, "_seq"});
    endtask

    initial begin
        logic [DP-1:0] exp_p;
        int n_part;

        // Reset
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with the consumer always ready
        prob_ready = 1'b1;
        run_frame(pack4(2, 0, 1, 1), 0, 0);

        // Backpressure for 10 cycles
        run_frame(pack4(1, 2, 2, 0), 0, 10);

        // Gapped input
        run_frame(pack4(0, 1, 2, 1), 1, 0);

        // Out-of-range symbol as the second entry
        run_frame(pack4(1, 3, 2, 2), 0, 2);

        // Abort after two symbols (second out of range), discarded handshake in the abort cycle
        push_sym(SW'(0), 0);
        push_sym(SW'(3), 0);
        pulse_abort(SW'((int'(exp_seq[2]) + 1) % NST));
        run_frame(pack4(2, 2, 1, 0), 0, 0);

        // Abort in HOLD while the consumer is ready: no handshake may happen
        for (int i = 0; i < LEN; i++) push_sym(SW'(i % NST), 0);
        wait_result();
        exp_p = exp_q.pop_front();
        chk("pre_abort_prob", prob_out, exp_p);
        prob_ready = 1'b1;
        pulse_abort(SW'(1));
        prob_ready = 1'b0;

        // Reset during SETTLE
        for (int i = 0; i < LEN; i++) push_sym(SW'(2 - (i % NST)), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SETTLE + 1) @(posedge clk);
        #1;
        chk("post_rst_pv", prob_valid, 0);
        chk("post_rst_ready", sym_ready, 1);

        // frame_count wrap
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frame_count;
        exp_fc = 16'hFFFF;
        chk("fc_forced", frame_count, exp_fc);
        run_frame(pack4(1, 1, 1, 1), 0, 0);
        chk("fc_wrap", frame_count, 16'h0000);

        // Randomized frames, with occasional partial frames killed by abort
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                n_part = $urandom_range(1, LEN - 1);
                for (int i = 0; i < n_part; i++) begin
                    push_sym(SW'($urandom_range(0, 3)), $urandom_range(0, 2));
                end
                pulse_abort(SW'($urandom_range(0, 3)));
            end
            run_frame(SW'($urandom_range(0, 3)) |
                      (8'($urandom_range(0, 3)) << 2) |
                      (8'($urandom_range(0, 3)) << 4) |
                      (8'($urandom_range(0, 3)) << 6),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
